// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store unit on a req/ack data bus; define MEM_ALIGN_CHECK_EN to abort misaligned accesses
module mem_access #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic        i_whilo,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  input  logic [7:0]  i_aluop,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_opv2,
  output logic        o_we,
  output logic [4:0]  o_waddr,
  output logic [31:0] o_wdata,
  output logic        o_whilo,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        stallreq,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        bus_err
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [4:0] cnt;
  logic abort;
  logic [31:0] ld_word;
  logic [1:0] a;
  logic is_lb, is_lbu, is_lh, is_lhu, is_lw, is_sb, is_sh, is_sw;
  logic is_load, is_store, is_mem, is_byte, is_half, is_word, misaligned;
  logic [3:0] be;
  logic [31:0] wd, ld_fmt;
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  assign a        = i_mem_addr[1:0];
  assign is_lb    = i_aluop == 8'hE0;
  assign is_lbu   = i_aluop == 8'hE1;
  assign is_lh    = i_aluop == 8'hE2;
  assign is_lhu   = i_aluop == 8'hE3;
  assign is_lw    = i_aluop == 8'hE4;
  assign is_sb    = i_aluop == 8'hE8;
  assign is_sh    = i_aluop == 8'hE9;
  assign is_sw    = i_aluop == 8'hEB;
  assign is_load  = is_lb | is_lbu | is_lh | is_lhu | is_lw;
  assign is_store = is_sb | is_sh | is_sw;
  assign is_mem   = is_load | is_store;
  assign is_byte  = is_lb | is_lbu | is_sb;
  assign is_half  = is_lh | is_lhu | is_sh;
  assign is_word  = is_lw | is_sw;
`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (is_half & a[0]) | (is_word & (a != 2'd0));
`else
  assign misaligned = 1'b0;
`endif
  assign be     = is_byte ? 4'b1000 >> a : is_half ? (a[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign wd     = is_byte ? {4{i_opv2[7:0]}} : is_half ? {2{i_opv2[15:0]}} : i_opv2;
  assign rbyte  = a == 2'd0 ? dm_rdata[31:24] : a == 2'd1 ? dm_rdata[23:16] :
                  a == 2'd2 ? dm_rdata[15:8] : dm_rdata[7:0];
  assign rhalf  = a[1] ? dm_rdata[15:0] : dm_rdata[31:16];
  assign ld_fmt = is_lb  ? {{24{rbyte[7]}}, rbyte} :
                  is_lbu ? {24'b0, rbyte} :
                  is_lh  ? {{16{rhalf[15]}}, rhalf} :
                  is_lhu ? {16'b0, rhalf} : dm_rdata;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_be    <= 4'b0;
      dm_addr  <= 32'b0;
      dm_wdata <= 32'b0;
      bus_err  <= 1'b0;
      cnt      <= 5'b0;
      abort    <= 1'b0;
      ld_word  <= 32'b0;
    end else begin
      bus_err <= 1'b0;
      if (state == IDLE) begin
        if (is_mem) begin
          state    <= misaligned ? DONE : REQ;
          dm_req   <= ~misaligned;
          dm_we    <= is_store;
          dm_be    <= be;
          dm_addr  <= {i_mem_addr[31:2], 2'b00};
          dm_wdata <= wd;
          cnt      <= 5'b0;
          abort    <= misaligned;
          bus_err  <= misaligned;
        end
      end else if (state == REQ) begin
        cnt <= cnt == 5'd31 ? cnt : cnt + 5'd1;
        if (dm_ack) begin
          ld_word <= ld_fmt;
          dm_req  <= 1'b0;
          state   <= DONE;
        end else if (cnt == 5'(ACK_TIMEOUT - 1)) begin
          dm_req  <= 1'b0;
          bus_err <= 1'b1;
          abort   <= 1'b1;
          state   <= DONE;
        end
      end else begin
        state <= IDLE;
      end
    end
  end
  logic pass, done;
  assign pass = state == IDLE & ~is_mem;
  assign done = state == DONE;
  always_comb begin
    stallreq = rst & ((state == IDLE & is_mem) | state == REQ);
    o_we     = rst & (pass ? i_we : done & i_we & is_load & ~abort);
    o_whilo  = rst & (pass | done) & i_whilo;
    o_waddr  = rst ? i_waddr : 5'b0;
    o_wdata  = !rst ? 32'b0 : done ? ld_word : i_wdata;
    o_hi     = rst ? i_hi : 32'b0;
    o_lo     = rst ? i_lo : 32'b0;
  end
endmodule
